// File: rtl/desc_alloc_rr_queue.sv
// rtl/desc_alloc_rr_queue.sv - round-robin descriptor allocator feeding read/write ID queues
module desc_id_fifo #(
    parameter int DEPTH = 16,
    parameter int ID_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head_id,
    output logic [ID_W:0]   count,
    output logic            full
);
    logic [ID_W-1:0] mem [DEPTH];
    logic [ID_W-1:0] wptr;
    logic [ID_W-1:0] rptr;

    // Storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_id;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_id = mem[rptr];
    assign full    = (count == (ID_W+1)'(DEPTH));
endmodule

module desc_alloc_rr_queue #(
    parameter int MAX_DESC = 16,
    localparam int ID_W    = $clog2(MAX_DESC)
) (
    input  logic                axi_aclk,
    input  logic                axi_areset,
    input  logic [MAX_DESC-1:0] uc2rb_ownership_reg,
    input  logic [MAX_DESC-1:0] desc_txn_type,
    input  logic                rd_hold,
    input  logic                wr_hold,
    input  logic                rd_req_ready,
    input  logic                wr_req_ready,
    output logic                rd_req_valid,
    output logic [ID_W-1:0]     rd_req_id,
    output logic                wr_req_valid,
    output logic [ID_W-1:0]     wr_req_id,
    output logic [ID_W:0]       rd_count,
    output logic [ID_W:0]       wr_count,
    output logic                dup_own_err
);
    logic [MAX_DESC-1:0] own_ff;
    logic [MAX_DESC-1:0] pend;
    logic [MAX_DESC-1:0] pulse;
    logic [MAX_DESC-1:0] elig;
    logic [MAX_DESC-1:0] grant_vec;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_vld;
    logic                rd_full;
    logic                wr_full;
    logic                rd_push;
    logic                wr_push;
    logic                rd_pop;
    logic                wr_pop;

    assign pulse = uc2rb_ownership_reg & ~own_ff;

    // A full queue only blocks descriptors headed for that queue.
    assign elig = pend & ((desc_txn_type & {MAX_DESC{~rd_full}}) |
                          (~desc_txn_type & {MAX_DESC{~wr_full}}));

    // Scan from the highest offset down so the nearest eligible bit at/after rr_ptr wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = MAX_DESC - 1; k >= 0; k--) begin
            idx = rr_ptr + ID_W'(k);
            if (elig[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign grant_vec = MAX_DESC'(grant_vld) << grant_idx;
    assign rd_push   = grant_vld &  desc_txn_type[grant_idx];
    assign wr_push   = grant_vld & ~desc_txn_type[grant_idx];

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            own_ff      <= '0;
            pend        <= '0;
            rr_ptr      <= '0;
            dup_own_err <= 1'b0;
        end else begin
            own_ff      <= uc2rb_ownership_reg;
            pend        <= pulse | (pend & ~grant_vec);
            dup_own_err <= dup_own_err | (|(pulse & pend & ~grant_vec));
            if (grant_vld) begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end

    assign rd_req_valid = (rd_count != '0) & ~rd_hold;
    assign wr_req_valid = (wr_count != '0) & ~wr_hold;
    assign rd_pop       = rd_req_valid & rd_req_ready;
    assign wr_pop       = wr_req_valid & wr_req_ready;

    desc_id_fifo #(.DEPTH(MAX_DESC), .ID_W(ID_W)) u_rd_q (
        .clk     (axi_aclk),
        .rst     (axi_areset),
        .push    (rd_push),
        .push_id (grant_idx),
        .pop     (rd_pop),
        .head_id (rd_req_id),
        .count   (rd_count),
        .full    (rd_full)
    );

    desc_id_fifo #(.DEPTH(MAX_DESC), .ID_W(ID_W)) u_wr_q (
        .clk     (axi_aclk),
        .rst     (axi_areset),
        .push    (wr_push),
        .push_id (grant_idx),
        .pop     (wr_pop),
        .head_id (wr_req_id),
        .count   (wr_count),
        .full    (wr_full)
    );
endmodule

// File: doc/desc_alloc_rr_queue.md
Name: desc_alloc_rr_queue

Overview:
Parametrised successor to the unified-channel master descriptor allocator. It detects rising edges on the per-descriptor ownership register and records each one as a pending request. Pending requests are granted round-robin into internal read and write ID queues. Each queue is presented to the AXI request generators through a valid/ready pop interface, with hold-off inputs and occupancy outputs.
New relative to the previous generation:
- any MAX_DESC
- packed txn-type vector
- round-robin grant with no head-of-line blocking
- one grant per cycle
- first-word-fall-through queues
- duplicate-ownership error flag

Parameters:
MAX_DESC, 16, number of descriptors; power of two, 2..64.
ID_W, derived = CLOG2(MAX_DESC), descriptor ID width; not overridable.

Ports:
axi_aclk  in  1  sole clock.
axi_areset  in  1  asynchronous, active-high reset.
uc2rb_ownership_reg  in  MAX_DESC  ownership bit per descriptor; a 0->1 edge is a new request.
desc_txn_type  in  MAX_DESC  bit i: 1 = read, 0 = write; sampled at grant.
rd_hold  in  1  read allocation in progress; masks rd_req_valid.
wr_hold  in  1  write allocation in progress or wdata pending FIFO full; masks wr_req_valid.
rd_req_ready  in  1  read consumer accepts head ID (AR handshake).
wr_req_ready  in  1  write consumer accepts head ID (AW handshake).
rd_req_valid  out  1  read queue non-empty and not held.
rd_req_id  out  ID_W  head of read queue.
wr_req_valid  out  1  write queue non-empty and not held.
wr_req_id  out  ID_W  head of write queue.
rd_count  out  ID_W+1  read queue occupancy.
wr_count  out  ID_W+1  write queue occupancy.
dup_own_err  out  1  sticky error flag; a rising edge arrived while that descriptor was still pending.

Behaviour:
Reset:
- Reset is asynchronous, active-high; all state clears immediately.
- Outputs at reset: valids 0, IDs 0, counts 0, dup_own_err 0.
- own_ff reset value is 0. Ownership bits already high when reset deasserts are therefore seen as edges in the first cycle after release.
- A reset mid-operation drops all pending and queued IDs.

Edge detect:
- own_ff <= uc2rb_ownership_reg (single flop).
- pulse = own & ~own_ff.

Pending:
- pend[i] sets on pulse[i] and clears on grant[i].
- If pulse[i] arrives while pend[i]=1 and grant[i]=0, the edge is dropped and dup_own_err is set.
- If pulse[i] and grant[i] occur in the same cycle, pend[i] stays 1 (new request kept) and no error is raised.

Eligibility and grant:
- elig[i] = pend[i] & (desc_txn_type[i] ? ~rd_full : ~wr_full).
- Grant selects the first elig bit at or above rr_ptr, wrapping modulo MAX_DESC; it is combinational.
- At most one grant per cycle, with no idle cycle between grants.
- On a grant to index g: push g into the queue selected by desc_txn_type[g], then rr_ptr <= (g+1) mod MAX_DESC.
- rr_ptr resets to 0 and is unchanged when there is no grant.
- A full queue blocks only descriptors of its own type.

Latency:
- Ownership rises before edge k: pend set at edge k, pushed at edge k+1 (if it wins), valid high after edge k+1.

Queues:
- Depth MAX_DESC, first-word fall-through.
- full = (count == MAX_DESC); empty = (count == 0).
- Pop occurs when valid & ready; valid = ~empty & ~hold.
- Push and pop in the same cycle: count unchanged, and the ID order is preserved.
- Read/write pointers wrap at MAX_DESC.
- A pop on an empty queue is impossible, because valid is 0.
- The ID and valid outputs are stable while valid=1 and ready=0.

Hold:
- Hold masks valid only; pushes continue while hold is asserted.

Test Plan:
- Reset, then ownership=0x0000 -> all outputs 0; assert axi_areset mid-stream -> counts 0 and valids 0 immediately, without waiting for a clock edge.
- ownership 0x0000->0x0005 with txn_type=0x0004 -> wr_req_valid with id 0 two cycles after the edge, rd id 2 the next cycle; wr_count=1, rd_count=1.
- ownership 0->0xFFFF, txn_type=0, wr_req_ready=1 -> write IDs 0,1,...,15 back to back, one per cycle; then set rr_ptr=5 via a prior grant of 4 and set pending {2,7} -> grant order 7 then 2.
- Fill the write queue to 16 with wr_req_ready=0, then add a read descriptor 3 -> rd id 3 is still granted; the write pend stays set until one pop occurs, then pushes on the next cycle.
- Pulse descriptor 9 twice while it is pending and its queue is full -> dup_own_err=1 (sticky); exactly one id 9 is queued.
- rd_hold=1 with rd_count=2 -> rd_req_valid=0 and pushes continue; push and pop in the same cycle at count=4 -> count stays 4 and order is preserved.
